mc_ctrl_fsm: RTL
================

Name: mc_ctrl_fsm

Overview:
Multi-cycle MIPS control unit. It replaces the single-cycle opcode decoder when the CPU moves to a shared-memory, multi-cycle datapath. It sequences fetch, decode, execute, memory and write-back over 3-5 cycles per instruction, stalling on a memory-ready handshake. It drives every datapath mux, enable and ALU-op line, and counts retired instructions.

Parameters:
CNT_W, 32, width of retired-instruction counter
OP_W, 6, opcode width (fixed 6, exposed for package sharing)

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  synchronous, active-high reset
instr_op_i  in  6  opcode from instruction register (IR[31:26])
funct_i  in  6  funct field from IR[5:0] (jr detect)
zero_i  in  1  ALU zero flag
mem_ready_i  in  1  memory completes current read/write this cycle
pc_write_o  out  1  unconditional PC load
pc_write_cond_o  out  1  PC load if zero_i (beq)
i_or_d_o  out  1  memory address: 0=PC, 1=ALUOut
mem_read_o  out  1  memory read request
mem_write_o  out  1  memory write request
ir_write_o  out  1  IR load
mdr_write_o  out  1  MDR load
reg_dst_o  out  2  00=rt, 01=rd, 10=$31
mem_to_reg_o  out  2  00=ALUOut, 01=MDR, 10=PC (link)
reg_write_o  out  1  register file write
alu_src_a_o  out  1  0=PC, 1=A
alu_src_b_o  out  2  00=B, 01=4, 10=sign-ext imm, 11=sign-ext imm<<2
alu_op_o  out  3  000 add, 001 sub, 010 funct, 011 addi, 100 slti
pc_src_o  out  2  00=ALU result, 01=ALUOut, 10=jump target, 11=A (jr)
illegal_o  out  1  one-cycle pulse on unknown opcode
state_o  out  4  current state (debug)
retired_o  out  CNT_W  instructions completed since reset

Behaviour:
- Reset (rst_i high at edge): state=FETCH, retired_o=0. All outputs take their FETCH values in the next cycle.
- rst_i mid-instruction aborts the instruction. No write enable is asserted in the cycle after reset.
- Unlisted outputs are 0 in each state.
- Outputs are Moore, except that pc_write_o and ir_write_o in FETCH, and mdr_write_o in MEMRD, are gated by mem_ready_i.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=000, pc_src=00. ir_write=pc_write=mem_ready_i. Stay while !mem_ready_i, else go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=000 (branch target to ALUOut). Next state by opcode:
  - 100011/101011 -> MEMADR
  - 000000 -> JR if funct_i==001000, else RTYPE
  - 000100 -> BEQ
  - 001000/001010 -> IMM
  - 000010 -> JUMP
  - 000011 -> JAL
  - other -> FETCH with illegal_o=1 for that cycle
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=000. Go to MEMRD if lw, else MEMWR.
- MEMRD: mem_read=1, i_or_d=1, mdr_write=mem_ready_i. Hold until mem_ready_i, then go to MEMWB.
- MEMWB: reg_write=1, reg_dst=00, mem_to_reg=01. Go to FETCH.
- MEMWR: mem_write=1, i_or_d=1. Hold until mem_ready_i, then go to FETCH.
- RTYPE: alu_src_a=1, alu_src_b=00, alu_op=010. Go to RWB.
- RWB: reg_write=1, reg_dst=01, mem_to_reg=00. Go to FETCH.
- IMM: alu_src_a=1, alu_src_b=10, alu_op=011 (addi) or 100 (slti). Go to IWB.
- IWB: reg_write=1, reg_dst=00, mem_to_reg=00. Go to FETCH.
- BEQ: alu_src_a=1, alu_src_b=00, alu_op=001, pc_write_cond=1, pc_src=01. Go to FETCH.
- JUMP: pc_write=1, pc_src=10. Go to FETCH.
- JAL: pc_write=1, pc_src=10, reg_write=1, reg_dst=10, mem_to_reg=10. PC already holds PC+4. Go to FETCH.
- JR: pc_write=1, pc_src=11. Go to FETCH.
- retired_o increments by 1 on entry to FETCH from any state except reset and the illegal path. It wraps modulo 2^CNT_W.
- Opcode is sampled from the IR only in DECODE. The IR is stable after FETCH, so later states use the same instr_op_i.
- Cycle counts with mem_ready_i always 1:
  - lw 5
  - sw, R-type, addi, slti 4
  - beq, j, jal, jr 3
- Each memory stall cycle adds exactly 1.

Decomposition:
- Shared package mc_pkg holds:
  - state enum (4-bit)
  - opcode constants (OP_RTYPE, OP_BEQ, OP_ADDI, OP_SLTI, OP_LW, OP_SW, OP_J, OP_JAL)
  - FUNCT_JR
  - ALU-op codes
  - mux-select codes
- Sub-module mc_ctrl_out: a purely combinational state-to-control-word decode. It is instantiated once; the FSM and counter stay in the top module.

Test Plan:
- Reset held 2 cycles, release, mem_ready_i=1 -> state_o=FETCH, mem_read_o=1, ir_write_o=1, retired_o=0.
- lw (op 100011), mem_ready_i low for 2 cycles in MEMRD -> states FETCH, DECODE, MEMADR, MEMRD×3, MEMWB. reg_write_o=1 with mem_to_reg_o=01 only in MEMWB. retired_o goes 0->1.
- beq with zero_i=1, then zero_i=0 -> pc_write_cond_o=1, pc_src_o=01 in BEQ in both cases. 3 cycles each, retired_o+=2.
- jal (000011) then jr (000000/001000) -> JAL: reg_dst_o=10, mem_to_reg_o=10, pc_write_o=1. JR: pc_src_o=11.
- Opcode 111111 -> illegal_o=1 for exactly one cycle in DECODE, back to FETCH, retired_o unchanged, no write enables asserted.
- rst_i asserted in MEMWR with mem_ready_i=0 -> next cycle state_o=FETCH, mem_write_o=0, retired_o=0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: state codes, opcodes,
// ALU-op and mux-select codes, and the packed control word.
package mc_pkg;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_RTYPE  = 4'd6;
  localparam logic [3:0] S_RWB    = 4'd7;
  localparam logic [3:0] S_IMM    = 4'd8;
  localparam logic [3:0] S_IWB    = 4'd9;
  localparam logic [3:0] S_BEQ    = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;
  localparam logic [3:0] S_JAL    = 4'd12;
  localparam logic [3:0] S_JR     = 4'd13;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FUNCT_JR = 6'b001000;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_ADDI  = 3'b011;
  localparam logic [2:0] ALU_SLTI  = 3'b100;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_A      = 2'b11;

  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iOrD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       mdrWrite;
    logic [1:0] regDst;
    logic [1:0] memToReg;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [2:0] aluOp;
    logic [1:0] pcSrc;
  } ctrlWord_t;

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Controller <-> datapath bundle: IR fields and flags in, every mux/enable out.
interface mc_ctrl_fsm_if;
  logic [5:0] instr_op_i;
  logic [5:0] funct_i;
  logic       zero_i;
  logic       mem_ready_i;
  logic       pc_write_o;
  logic       pc_write_cond_o;
  logic       i_or_d_o;
  logic       mem_read_o;
  logic       mem_write_o;
  logic       ir_write_o;
  logic       mdr_write_o;
  logic [1:0] reg_dst_o;
  logic [1:0] mem_to_reg_o;
  logic       reg_write_o;
  logic       alu_src_a_o;
  logic [1:0] alu_src_b_o;
  logic [2:0] alu_op_o;
  logic [1:0] pc_src_o;

  modport master (
    input  instr_op_i, funct_i, zero_i, mem_ready_i,
    output pc_write_o, pc_write_cond_o, i_or_d_o, mem_read_o, mem_write_o,
           ir_write_o, mdr_write_o, reg_dst_o, mem_to_reg_o, reg_write_o,
           alu_src_a_o, alu_src_b_o, alu_op_o, pc_src_o
  );

  modport slave (
    output instr_op_i, funct_i, zero_i, mem_ready_i,
    input  pc_write_o, pc_write_cond_o, i_or_d_o, mem_read_o, mem_write_o,
           ir_write_o, mdr_write_o, reg_dst_o, mem_to_reg_o, reg_write_o,
           alu_src_a_o, alu_src_b_o, alu_op_o, pc_src_o
  );
endinterface

// File: rtl/mc_ctrl_out.sv
// Combinational state-to-control-word decode; the only non-Moore terms are the
// fetch/MDR load enables, which wait on the memory handshake.
module mc_ctrl_out
  import mc_pkg::*;
(
  input  logic [3:0] state,
  input  logic       isSlti,
  input  logic       memReady,
  output ctrlWord_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.memRead = 1'b1;
        ctrl.aluSrcB = SRCB_FOUR;
        ctrl.irWrite = memReady;
        ctrl.pcWrite = memReady;
      end
      S_DECODE: ctrl.aluSrcB = SRCB_IMM_SH;
      S_MEMADR: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.memRead  = 1'b1;
        ctrl.iOrD     = 1'b1;
        ctrl.mdrWrite = memReady;
      end
      S_MEMWB: begin
        ctrl.regWrite = 1'b1;
        ctrl.memToReg = M2R_MDR;
      end
      S_MEMWR: begin
        ctrl.memWrite = 1'b1;
        ctrl.iOrD     = 1'b1;
      end
      S_RTYPE: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluOp   = ALU_FUNCT;
      end
      S_RWB: begin
        ctrl.regWrite = 1'b1;
        ctrl.regDst   = REGDST_RD;
      end
      S_IMM: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_IMM;
        ctrl.aluOp   = isSlti ? ALU_SLTI : ALU_ADDI;
      end
      S_IWB: ctrl.regWrite = 1'b1;
      S_BEQ: begin
        ctrl.aluSrcA     = 1'b1;
        ctrl.aluOp       = ALU_SUB;
        ctrl.pcWriteCond = 1'b1;
        ctrl.pcSrc       = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pcWrite = 1'b1;
        ctrl.pcSrc   = PCSRC_JUMP;
      end
      S_JAL: begin
        // PC already holds PC+4 from fetch, so it is the link value
        ctrl.pcWrite  = 1'b1;
        ctrl.pcSrc    = PCSRC_JUMP;
        ctrl.regWrite = 1'b1;
        ctrl.regDst   = REGDST_RA;
        ctrl.memToReg = M2R_PC;
      end
      S_JR: begin
        ctrl.pcWrite = 1'b1;
        ctrl.pcSrc   = PCSRC_A;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control unit: sequences fetch/decode/execute/memory/write-back
// and counts retired instructions.
//
// state  | meaning
// FETCH  | read instruction at PC, PC <= PC+4 when memory ready
// DECODE | compute branch target into ALUOut, dispatch on opcode
// MEMADR | effective address for lw/sw
// MEMRD  | load data into MDR, wait on memory
// MEMWB  | MDR -> rt
// MEMWR  | store B, wait on memory
// RTYPE  | ALU op from funct
// RWB    | ALUOut -> rd
// IMM    | addi/slti with sign-extended immediate
// IWB    | ALUOut -> rt
// BEQ    | compare, conditional PC load from ALUOut
// JUMP   | PC <= jump target
// JAL    | PC <= jump target, PC+4 -> $31
// JR     | PC <= A
module mc_ctrl_fsm
  import mc_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int OP_W  = 6
) (
  input  logic              clk_i,
  input  logic              rst_i,
  mc_ctrl_fsm_if.master     bus,
  output logic              illegal_o,
  output logic [3:0]        state_o,
  output logic [CNT_W-1:0]  retired_o
);

  logic [3:0]      state;
  logic [3:0]      nextState;
  logic [OP_W-1:0] opcode;
  logic            isIllegal;
  logic            retire;
  logic [CNT_W-1:0] retiredCnt;
  ctrlWord_t       ctrl;

  assign opcode = bus.instr_op_i;

  always_comb begin
    nextState = state;
    isIllegal = 1'b0;
    case (state)
      S_FETCH:  nextState = bus.mem_ready_i ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:     nextState = S_MEMADR;
          OP_RTYPE:         nextState = (bus.funct_i == FUNCT_JR) ? S_JR : S_RTYPE;
          OP_BEQ:           nextState = S_BEQ;
          OP_ADDI, OP_SLTI: nextState = S_IMM;
          OP_J:             nextState = S_JUMP;
          OP_JAL:           nextState = S_JAL;
          default: begin
            nextState = S_FETCH;
            isIllegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: nextState = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  nextState = bus.mem_ready_i ? S_MEMWB : S_MEMRD;
      S_MEMWR:  nextState = bus.mem_ready_i ? S_FETCH : S_MEMWR;
      S_RTYPE:  nextState = S_RWB;
      S_IMM:    nextState = S_IWB;
      S_MEMWB, S_RWB, S_IWB, S_BEQ, S_JUMP, S_JAL, S_JR: nextState = S_FETCH;
      default:  nextState = S_FETCH;
    endcase
  end

  // Fetch stalls and the illegal-opcode exit from DECODE are not retirements
  assign retire = (nextState == S_FETCH) && (state != S_FETCH) && (state != S_DECODE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_FETCH;
      retiredCnt <= '0;
    end else begin
      state <= nextState;
      if (retire) retiredCnt <= retiredCnt + CNT_W'(1);
    end
  end

  mc_ctrl_out u_ctrl_out (
    .state    (state),
    .isSlti   (opcode == OP_SLTI),
    .memReady (bus.mem_ready_i),
    .ctrl     (ctrl)
  );

  assign bus.pc_write_o      = ctrl.pcWrite;
  assign bus.pc_write_cond_o = ctrl.pcWriteCond;
  assign bus.i_or_d_o        = ctrl.iOrD;
  assign bus.mem_read_o      = ctrl.memRead;
  assign bus.mem_write_o     = ctrl.memWrite;
  assign bus.ir_write_o      = ctrl.irWrite;
  assign bus.mdr_write_o     = ctrl.mdrWrite;
  assign bus.reg_dst_o       = ctrl.regDst;
  assign bus.mem_to_reg_o    = ctrl.memToReg;
  assign bus.reg_write_o     = ctrl.regWrite;
  assign bus.alu_src_a_o     = ctrl.aluSrcA;
  assign bus.alu_src_b_o     = ctrl.aluSrcB;
  assign bus.alu_op_o        = ctrl.aluOp;
  assign bus.pc_src_o        = ctrl.pcSrc;

  assign illegal_o = isIllegal;
  assign state_o   = state;
  assign retired_o = retiredCnt;

endmodule
